// File: rtl/multi_sensor_pkg.sv
// ============================================================================
// Module      : multi_sensor_pkg
// Description : Shared types and default constants for the multi-sensor
//               stimulus generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multi_sensor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int NUM_SENSORS_DEF = 4;
    localparam int CNT_W_DEF       = 16;
    localparam int TIMEOUT_DEF     = 1000;

    typedef enum logic [1:0] {
        RES_NONE    = 2'd0,
        RES_PASS    = 2'd1,
        RES_FAIL    = 2'd2,
        RES_TIMEOUT = 2'd3
    } result_e;

endpackage

`default_nettype wire

// File: rtl/multi_sensor_stimulus_gen_resp_edge_detect.sv
// ============================================================================
// Module      : resp_edge_detect
// Description : Rising-edge detector on the checker response line, with an
//               optional 2-flop synchronizer (SENSOR_RESP_SYNC_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module resp_edge_detect
    import multi_sensor_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_ena,
    input  logic i_resp,
    output logic o_edge
);

    logic w_resp;
    logic r_prev;

`ifdef SENSOR_RESP_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // Synchronizer freezes with ena so latency stays counted in enabled cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else if (i_ena) begin
            r_sync1 <= i_resp;
            r_sync2 <= r_sync1;
        end
    end

    assign w_resp = r_sync2;
`else
    assign w_resp = i_resp;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
        end else if (i_ena) begin
            r_prev <= w_resp;
        end
    end

    assign o_edge = i_ena & w_resp & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/multi_sensor_stimulus_gen.sv
// ============================================================================
// Module      : multi_sensor_stimulus_gen
// Description : Drives a programmed sensor pattern, measures the response
//               latency and reports pass / fail / timeout.
//               Optional macro: SENSOR_RESP_SYNC_EN (synchronize resp_in).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_sensor_stimulus_gen
    import multi_sensor_pkg::*;
#(
    parameter int NUM_SENSORS = NUM_SENSORS_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_ena,
    input  logic                   i_start,
    input  logic [NUM_SENSORS-1:0] i_pattern,
    input  logic [CNT_W-1:0]       i_hold_cycles,
    input  logic                   i_expect_resp,
    input  logic                   i_resp_in,
    output logic [NUM_SENSORS-1:0] o_sensor_out,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_pass,
    output logic                   o_timeout,
    output logic [CNT_W-1:0]       o_latency
);

    localparam logic [1:0]       c_ST_IDLE      = 2'(IDLE);
    localparam logic [1:0]       c_ST_DRIVE     = 2'(DRIVE);
    localparam logic [1:0]       c_ST_WAIT      = 2'(WAIT);
    localparam logic [1:0]       c_ST_DONE      = 2'(DONE);
    localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_ONE          = CNT_W'(1);

    logic [1:0]             r_state;
    logic [NUM_SENSORS-1:0] r_pattern;
    logic [CNT_W-1:0]       r_hold;
    logic                   r_expect;
    logic [CNT_W-1:0]       r_elapsed;
    logic                   r_pass;
    logic                   r_timeout;
    logic [CNT_W-1:0]       r_latency;
    logic                   w_edge;

    resp_edge_detect u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_ena  (i_ena),
        .i_resp (i_resp_in),
        .o_edge (w_edge)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_pattern <= '0;
            r_hold    <= '0;
            r_expect  <= 1'b0;
            r_elapsed <= '0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
            r_latency <= '0;
        end else if (i_ena) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (i_start) begin
                        r_pattern <= i_pattern;
                        r_hold    <= (i_hold_cycles == '0) ? c_ONE : i_hold_cycles;
                        r_expect  <= i_expect_resp;
                        r_pass    <= 1'b0;
                        r_timeout <= 1'b0;
                        r_latency <= '0;
                        r_elapsed <= '0;
                        r_state   <= c_ST_DRIVE;
                    end
                end
                c_ST_DRIVE, c_ST_WAIT: begin
                    if (r_elapsed != '1) begin
                        r_elapsed <= r_elapsed + c_ONE;
                    end
                    // Response beats timeout; pass is resolved here so it is valid during DONE
                    if (w_edge) begin
                        r_latency <= r_elapsed;
                        r_pass    <= r_expect;
                        r_state   <= c_ST_DONE;
                    end else if (r_elapsed == c_TIMEOUT_LAST) begin
                        r_timeout <= 1'b1;
                        r_latency <= '0;
                        r_pass    <= ~r_expect;
                        r_state   <= c_ST_DONE;
                    end else if ((r_state == c_ST_DRIVE) && (r_elapsed == r_hold - c_ONE)) begin
                        r_state   <= c_ST_WAIT;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign o_sensor_out = (r_state == c_ST_DRIVE) ? r_pattern : '0;
    assign o_busy       = (r_state == c_ST_DRIVE) || (r_state == c_ST_WAIT);
    assign o_done       = (r_state == c_ST_DONE);
    assign o_pass       = r_pass;
    assign o_timeout    = r_timeout;
    assign o_latency    = r_latency;

endmodule

`default_nettype wire

// File: tb/tb_multi_sensor_stimulus_gen.sv
// ============================================================================
// Module      : tb_multi_sensor_stimulus_gen
// Description : Self-checking bench; directed and random tests against a
//               timeline model of the stimulus generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_multi_sensor_stimulus_gen;

    localparam int NS = 4;
    localparam int CW = 16;
    localparam int TO = 20;
`ifdef SENSOR_RESP_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b0;
    logic          start = 1'b0;
    logic [NS-1:0] pattern = '0;
    logic [CW-1:0] hold_cycles = '0;
    logic          expect_resp = 1'b0;
    logic          resp_in = 1'b0;
    logic [NS-1:0] sensor_out;
    logic          busy;
    logic          done;
    logic          pass;
    logic          timeout;
    logic [CW-1:0] latency;

    int n_cmp = 0;
    int n_err = 0;

    multi_sensor_stimulus_gen #(
        .NUM_SENSORS (NS),
        .CNT_W       (CW),
        .TIMEOUT     (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_ena         (ena),
        .i_start       (start),
        .i_pattern     (pattern),
        .i_hold_cycles (hold_cycles),
        .i_expect_resp (expect_resp),
        .i_resp_in     (resp_in),
        .o_sensor_out  (sensor_out),
        .o_busy        (busy),
        .o_done        (done),
        .o_pass        (pass),
        .o_timeout     (timeout),
        .o_latency     (latency)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One complete test; expectations come from the timeline of enabled cycles
    task automatic run_test(input logic [NS-1:0] pat, input int hold, input bit exp,
                            input int resp_at, input bit pre_high,
                            input int gap_at, input int gap_len, input bit swait);
        int hold_eff, resp_eff, end_k, drive_end, exp_lat, e, gap_left;
        bit got, exp_to, exp_pass;
        hold_eff  = (hold == 0) ? 1 : hold;
        resp_eff  = (resp_at >= 0) ? resp_at + SYNC_LAT : -1;
        got       = (resp_eff >= 0) && (resp_eff <= TO - 1);
        end_k     = got ? resp_eff : TO - 1;
        exp_lat   = got ? resp_eff : 0;
        exp_to    = !got;
        exp_pass  = (got == exp);
        drive_end = (hold_eff < end_k + 1) ? hold_eff : end_k + 1;

        ena = 1'b1; start = 1'b0; resp_in = pre_high;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; pattern = pat; hold_cycles = CW'(hold); expect_resp = exp;
        @(posedge clk);
        #1;
        start = 1'b0;
        e = 0;
        gap_left = gap_len;
        while (e <= end_k + 1) begin
            if (e == gap_at && gap_left > 0) begin
                ena = 1'b0;
                gap_left--;
            end else begin
                ena = 1'b1;
            end
            resp_in = (resp_at >= 0 && e >= resp_at) ? 1'b1 : pre_high;
            if (swait && e == hold_eff && hold_eff < end_k) begin
                start = 1'b1; pattern = ~pat; hold_cycles = CW'(1);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            chk("sensor_out", 32'(sensor_out), (e < drive_end) ? 32'(pat) : 32'd0);
            chk("busy", 32'(busy), 32'(e <= end_k));
            chk("done", 32'(done), 32'(e == end_k + 1));
            if (e == end_k + 1) begin
                chk("pass", 32'(pass), 32'(exp_pass));
                chk("timeout", 32'(timeout), 32'(exp_to));
                chk("latency", 32'(latency), 32'(exp_lat));
            end
            @(posedge clk);
            #1;
            if (ena) e++;
        end
        start = 1'b0; ena = 1'b1;
        @(negedge clk);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("hold_pass", 32'(pass), 32'(exp_pass));
        chk("hold_latency", 32'(latency), 32'(exp_lat));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sensor_out", 32'(sensor_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_latency", 32'(latency), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // pattern, hold, expect, resp_at, pre_high, gap_at, gap_len, start_in_wait
        run_test(4'b1010,  5, 1'b1, 12, 1'b0, -1, 0, 1'b0);
        run_test(4'b0001,  3, 1'b1, -1, 1'b0, -1, 0, 1'b0);
        run_test(4'b0110,  4, 1'b0, -1, 1'b0, -1, 0, 1'b0);
        run_test(4'b1100,  4, 1'b0,  4, 1'b0, -1, 0, 1'b0);
        run_test(4'b1111, 10, 1'b1,  2, 1'b0, -1, 0, 1'b0);
        run_test(4'b0101,  0, 1'b1,  8, 1'b0, -1, 0, 1'b0);
        run_test(4'b0011,  3, 1'b1, -1, 1'b1, -1, 0, 1'b0);
        run_test(4'b1001,  4, 1'b1, 10, 1'b0, -1, 0, 1'b1);
        run_test(4'b0111, 10, 1'b1, 15, 1'b0,  3, 7, 1'b0);
        run_test(4'b1000,  2, 1'b1, 19, 1'b0, -1, 0, 1'b0);

        // Reset asserted in WAIT must clear outputs without waiting for a clock
        ena = 1'b1; resp_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; pattern = 4'b1011; hold_cycles = CW'(2); expect_resp = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sensor_out", 32'(sensor_out), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_pass", 32'(pass), 32'd0);
        chk("mid_rst_timeout", 32'(timeout), 32'd0);
        chk("mid_rst_latency", 32'(latency), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_test(4'b1101, 6, 1'b1, 7, 1'b0, -1, 0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            int r_at;
            int g_at;
            bit ph;
            r_at = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 22));
            ph   = (r_at < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            g_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 10)) : -1;
            run_test(NS'($urandom), int'($urandom_range(0, 25)), 1'($urandom_range(0, 1)),
                     r_at, ph, g_at, int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multi_sensor_stimulus_gen.md
Name: multi_sensor_stimulus_gen

Overview:
- Bench-side / on-chip self-test counterpart of the multi-sensor response checker. It drives a programmed pattern onto the sensor lines, then watches the checker's response line.
- It measures the response latency in clock cycles and flags pass, fail or timeout.
- It sits beside the checker in the TinyTapeout harness. Its outputs feed the checker's sensor inputs, and the checker's alarm/response output feeds back into it.

Parameters:
- NUM_SENSORS, 4, width of the sensor pattern and of sensor_out.
- CNT_W, 16, width of the hold and latency counters.
- TIMEOUT, 1000, cycles (counted from the first DRIVE cycle) before giving up; must be ≥ 2 and ≤ 2^CNT_W − 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  design enable; when low, the FSM and counters freeze and outputs hold.
- start  in  1  begin a test; sampled only in IDLE with ena=1.
- pattern  in  NUM_SENSORS  sensor pattern to drive; latched on start.
- hold_cycles  in  CNT_W  number of cycles to drive the pattern; latched on start; 0 is treated as 1.
- expect_resp  in  1  1 = a response is required; 0 = a response must not occur (negative test); latched on start.
- resp_in  in  1  response line from the checker.
- sensor_out  out  NUM_SENSORS  stimulus to the checker.
- busy  out  1  high in DRIVE and WAIT.
- done  out  1  one-cycle pulse at the end of a test.
- pass  out  1  result; valid from done until the next start.
- timeout  out  1  no response within TIMEOUT; valid from done until the next start.
- latency  out  CNT_W  cycles from the first DRIVE cycle to the response edge; 0 if no response.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE. sensor_out, busy, done, pass, timeout, latency and all internal registers are 0, including the resp_in previous-value register. Asserting reset mid-test aborts it immediately with the same values.
- States: IDLE, DRIVE, WAIT, DONE. All transitions happen only on cycles with ena=1.
- IDLE:
  - On start=1, latch pattern, hold_cycles (max(1, value)) and expect_resp.
  - Clear pass, timeout and latency. Set elapsed=0 and go to DRIVE.
  - start in any other state is ignored.
- DRIVE:
  - sensor_out = latched pattern; busy=1.
  - elapsed increments each cycle; the first DRIVE cycle has elapsed=0.
  - After hold_cycles DRIVE cycles, go to WAIT with sensor_out=0.
- WAIT: sensor_out=0, busy=1, elapsed keeps incrementing.
- Response detection:
  - A response is a rising edge of resp_in: sampled high now, and low on the previous enabled cycle.
  - A line already high at start is not a response until it falls and rises again.
  - An edge in DRIVE or WAIT at elapsed=k sets latency=k, seen=1, and moves the FSM to DONE next cycle. An edge in DRIVE also cuts the drive short: sensor_out goes to 0 in DONE.
- Timeout:
  - If elapsed = TIMEOUT−1 with no edge that cycle, set timeout=1 and latency=0, then go to DONE.
  - A response edge and the timeout in the same cycle: the response wins and timeout=0.
- DONE: done=1 for exactly one enabled cycle; pass = (seen == expect_resp); sensor_out=0; busy=0; then IDLE.
- Result hold: pass, timeout and latency hold their values in IDLE until the next accepted start.
- ena=0: all state, counters and outputs hold. A done pulse in progress is stretched until ena returns. Edge detection compares enabled-cycle samples only.
- Arithmetic: elapsed is CNT_W bits and saturates at all-ones; it cannot wrap, given the TIMEOUT bound.

Optional Feature:
- Macro: SENSOR_RESP_SYNC_EN.
- Defined: resp_in passes through a 2-flop synchronizer (reset to 0) before edge detection. All measured latencies grow by exactly 2 cycles, and an edge arriving in the last 2 cycles before timeout is missed.
- Undefined: resp_in feeds the edge detector directly and is assumed synchronous to clk.

Decomposition:
- Shared package multi_sensor_pkg holds:
  - the state enum (IDLE=2'd0, DRIVE=2'd1, WAIT=2'd2, DONE=2'd3);
  - default constants NUM_SENSORS_DEF=4, CNT_W_DEF=16, TIMEOUT_DEF=1000;
  - the result-code typedef.
- One sub-module is natural: resp_edge_detect, which contains the optional synchronizer plus the rising-edge register and honours ena.
- The FSM and counters stay in the top module.

Test Plan:
- Positive test: pattern=4'b1010, hold=5, expect=1; resp_in rises at elapsed=12 → sensor_out=1010 for 5 cycles, then 0; done one cycle later; pass=1, timeout=0, latency=12 (14 with SENSOR_RESP_SYNC_EN).
- Timeout test: pattern=4'b0001, hold=3, expect=1, no response, TIMEOUT=20 → done after elapsed=19; pass=0, timeout=1, latency=0.
- Negative test: expect=0, no response → timeout=1, pass=1. Then expect=0 with a response at elapsed=4 → pass=0, latency=4.
- Early response: hold=10, response at elapsed=2 → sensor_out drops to 0 on the next cycle; latency=2; busy low in DONE.
- Boundary and control: hold_cycles=0 behaves as 1; resp_in already high at start yields a timeout; start pulsed during WAIT is ignored; ena held low for 7 cycles mid-DRIVE extends the drive by exactly 7 cycles and latency is unchanged.
- Reset mid-test: rst_n asserted in WAIT → sensor_out, busy, done, pass, timeout and latency are all 0 immediately. After release, a new start=1 works normally.
